// File: rtl/stack_arbiter.sv
// Two-client round-robin arbiter in front of an external stack (push/pop/get by depth).
// Latency: request sampled at posedge k -> GNT in cycle k+1 -> DONE/ERR/RDATA in cycle k+3.
// Backpressure: one op in flight; clients hold REQ until GNT, requests outside IDLE wait.
module stack_arbiter #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ_A,
    input  logic             REQ_B,
    input  logic [1:0]       CMD_A,
    input  logic [1:0]       CMD_B,
    input  logic [2:0]       IDX_A,
    input  logic [2:0]       IDX_B,
    input  logic [WIDTH-1:0] WDATA_A,
    input  logic [WIDTH-1:0] WDATA_B,
    output logic             GNT_A,
    output logic             GNT_B,
    output logic             DONE_A,
    output logic             DONE_B,
    output logic             ERR_A,
    output logic             ERR_B,
    output logic [WIDTH-1:0] RDATA_A,
    output logic [WIDTH-1:0] RDATA_B,
    output logic [1:0]       STK_COMMAND,
    output logic [2:0]       STK_INDEX,
    output logic [WIDTH-1:0] STK_DOUT,
    output logic             STK_OE,
    input  logic [WIDTH-1:0] STK_DIN,
    output logic             STK_RESET,
    output logic [2:0]       COUNT
);

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_PUSH = 2'b01;
    localparam logic [1:0] CMD_POP  = 2'b10;
    localparam logic [1:0] CMD_GET  = 2'b11;
    localparam logic [2:0] DEPTH_C  = 3'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             win_b_q;     // 1 when the op in flight belongs to client B
    logic             prio_b_q;    // 1 when B wins the next tie
    logic [1:0]       cmd_q;
    logic [2:0]       idx_q;
    logic [WIDTH-1:0] wdata_q;
    logic             legal_q;     // legality decided in ISSUE, used by WAIT/DONE
    logic             stk_rst_q;   // held through the first cycle after reset release
    logic [2:0]       count_q;
    logic             take;
    logic             pick_b;
    logic             legal;
    logic             read_op;

    // A request is taken only in IDLE and never during the stack-clear cycle.
    assign take    = (state_q == S_IDLE) && !stk_rst_q && (REQ_A || REQ_B);
    assign pick_b  = REQ_B && (!REQ_A || prio_b_q);
    assign read_op = (cmd_q == CMD_POP) || (cmd_q == CMD_GET);

    // Legality of the latched op against the current occupancy.
    always_comb begin
        legal = 1'b1;
        case (cmd_q)
            CMD_NOP:  legal = 1'b1;
            CMD_PUSH: legal = (count_q != DEPTH_C);
            CMD_POP:  legal = (count_q != 3'd0);
            CMD_GET:  legal = (idx_q < count_q);
            default:  legal = 1'b1;
        endcase
    end

    // Next-state sequencing and all decoded outputs.
    always_comb begin
        state_d     = state_q;
        GNT_A       = 1'b0;
        GNT_B       = 1'b0;
        DONE_A      = 1'b0;
        DONE_B      = 1'b0;
        ERR_A       = 1'b0;
        ERR_B       = 1'b0;
        STK_COMMAND = CMD_NOP;
        STK_INDEX   = 3'd0;
        STK_DOUT    = '0;
        STK_OE      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (take) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                GNT_A   = !win_b_q;
                GNT_B   = win_b_q;
                if (legal) begin
                    STK_COMMAND = cmd_q;
                    STK_INDEX   = idx_q;
                end
                if (legal && (cmd_q == CMD_PUSH)) begin
                    STK_OE   = 1'b1;
                    STK_DOUT = wdata_q;
                end
            end
            S_WAIT: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                DONE_A  = !win_b_q;
                DONE_B  = win_b_q;
                ERR_A   = !win_b_q && !legal_q;
                ERR_B   = win_b_q && !legal_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register, request latch, round-robin pointer and occupancy.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            win_b_q   <= 1'b0;
            prio_b_q  <= 1'b0;
            cmd_q     <= CMD_NOP;
            idx_q     <= 3'd0;
            wdata_q   <= '0;
            legal_q   <= 1'b0;
            stk_rst_q <= 1'b1;
            count_q   <= 3'd0;
        end else begin
            state_q   <= state_d;
            stk_rst_q <= 1'b0;
            if (take) begin
                win_b_q  <= pick_b;
                prio_b_q <= !pick_b;
                cmd_q    <= pick_b ? CMD_B   : CMD_A;
                idx_q    <= pick_b ? IDX_B   : IDX_A;
                wdata_q  <= pick_b ? WDATA_B : WDATA_A;
            end
            if (state_q == S_ISSUE) begin
                legal_q <= legal;
                if (legal && (cmd_q == CMD_PUSH)) count_q <= count_q + 3'd1;
                if (legal && (cmd_q == CMD_POP))  count_q <= count_q - 3'd1;
            end
        end
    end

    // Result capture for the winner at the end of WAIT; zero unless a legal read.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            RDATA_A <= '0;
            RDATA_B <= '0;
        end else if (state_q == S_WAIT) begin
            if (win_b_q) RDATA_B <= (legal_q && read_op) ? STK_DIN : '0;
            else         RDATA_A <= (legal_q && read_op) ? STK_DIN : '0;
        end
    end

    assign STK_RESET = stk_rst_q;
    assign COUNT     = count_q;

endmodule

// File: tb/tb_stack_arbiter.sv
module tb_stack_arbiter;

    logic       CLK, RESET;
    logic       REQ_A, REQ_B;
    logic [1:0] CMD_A, CMD_B;
    logic [2:0] IDX_A, IDX_B;
    logic [3:0] WDATA_A, WDATA_B;
    logic       GNT_A, GNT_B, DONE_A, DONE_B, ERR_A, ERR_B;
    logic [3:0] RDATA_A, RDATA_B;
    logic [1:0] STK_COMMAND;
    logic [2:0] STK_INDEX;
    logic [3:0] STK_DOUT;
    logic       STK_OE;
    logic [3:0] STK_DIN;
    logic       STK_RESET;
    logic [2:0] COUNT;

    int vecs = 0;
    int miss = 0;
    logic [3:0] rd_a_exp = 4'h0;
    logic [3:0] rd_b_exp = 4'h0;
    int lat;

    stack_arbiter #(.DEPTH(5), .WIDTH(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_A(REQ_A), .REQ_B(REQ_B),
        .CMD_A(CMD_A), .CMD_B(CMD_B),
        .IDX_A(IDX_A), .IDX_B(IDX_B),
        .WDATA_A(WDATA_A), .WDATA_B(WDATA_B),
        .GNT_A(GNT_A), .GNT_B(GNT_B),
        .DONE_A(DONE_A), .DONE_B(DONE_B),
        .ERR_A(ERR_A), .ERR_B(ERR_B),
        .RDATA_A(RDATA_A), .RDATA_B(RDATA_B),
        .STK_COMMAND(STK_COMMAND), .STK_INDEX(STK_INDEX),
        .STK_DOUT(STK_DOUT), .STK_OE(STK_OE),
        .STK_DIN(STK_DIN), .STK_RESET(STK_RESET),
        .COUNT(COUNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // External stack model: acts on the command bus at the posedge closing ISSUE.
    logic [3:0] mem [8];
    int         sp = 0;
    logic [3:0] din = 4'h0;
    assign STK_DIN = din;

    always @(posedge CLK) begin
        if (STK_RESET) begin
            sp <= 0;
        end else begin
            case (STK_COMMAND)
                2'b01: if (STK_OE && sp < 8) begin
                    mem[sp] <= STK_DOUT;
                    sp      <= sp + 1;
                end
                2'b10: if (sp > 0) begin
                    din <= mem[sp-1];
                    sp  <= sp - 1;
                end
                2'b11: if (sp - 1 - int'(STK_INDEX) >= 0) din <= mem[sp-1-int'(STK_INDEX)];
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete operation: raise requests, wait for the grant, check ISSUE/WAIT/DONE.
    task automatic do_op(input string tag, input bit ra, input bit rb, input bit exp_b,
                         input logic [1:0] cmd, input logic [2:0] idx, input logic [3:0] wd,
                         input bit exp_err, input logic [3:0] exp_rd, input logic [2:0] exp_cnt,
                         output int n);
        bit         lgl_push;
        logic [1:0] exp_cmd;
        if (ra) begin REQ_A = 1'b1; CMD_A = cmd; IDX_A = idx; WDATA_A = wd; end
        if (rb) begin REQ_B = 1'b1; CMD_B = cmd; IDX_B = idx; WDATA_B = wd; end
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(GNT_A || GNT_B) && n < 10);
        lgl_push = !exp_err && (cmd == 2'b01);
        exp_cmd  = exp_err ? 2'b00 : cmd;
        // ISSUE cycle
        chk({tag, " gnt"}, {6'd0, GNT_A, GNT_B}, exp_b ? 8'h01 : 8'h02);
        chk({tag, " issue cmd"}, {6'd0, STK_COMMAND}, {6'd0, exp_cmd});
        chk({tag, " issue oe"}, {7'd0, STK_OE}, {7'd0, lgl_push});
        chk({tag, " issue dout"}, {4'd0, STK_DOUT}, lgl_push ? {4'd0, wd} : 8'h00);
        REQ_A = 1'b0; CMD_A = 2'b00; IDX_A = 3'd0; WDATA_A = 4'h0;
        REQ_B = 1'b0; CMD_B = 2'b00; IDX_B = 3'd0; WDATA_B = 4'h0;
        // WAIT cycle
        @(negedge CLK);
        chk({tag, " wait cmd"}, {5'd0, STK_OE, STK_COMMAND}, 8'h00);
        chk({tag, " wait gnt/done"}, {4'd0, GNT_A, GNT_B, DONE_A, DONE_B}, 8'h00);
        // DONE cycle
        @(negedge CLK);
        chk({tag, " done"}, {6'd0, DONE_A, DONE_B}, exp_b ? 8'h01 : 8'h02);
        chk({tag, " err"}, {6'd0, ERR_A, ERR_B}, exp_b ? {7'd0, exp_err} : {6'd0, exp_err, 1'b0});
        chk({tag, " done cmd"}, {6'd0, STK_COMMAND}, 8'h00);
        chk({tag, " count"}, {5'd0, COUNT}, {5'd0, exp_cnt});
        if (exp_b) begin
            chk({tag, " rdata_b"}, {4'd0, RDATA_B}, {4'd0, exp_rd});
            chk({tag, " rdata_a held"}, {4'd0, RDATA_A}, {4'd0, rd_a_exp});
            rd_b_exp = exp_rd;
        end else begin
            chk({tag, " rdata_a"}, {4'd0, RDATA_A}, {4'd0, exp_rd});
            chk({tag, " rdata_b held"}, {4'd0, RDATA_B}, {4'd0, rd_b_exp});
            rd_a_exp = exp_rd;
        end
    endtask

    initial begin
        RESET = 1'b1;
        REQ_A = 1'b0; REQ_B = 1'b0;
        CMD_A = 2'b00; CMD_B = 2'b00;
        IDX_A = 3'd0; IDX_B = 3'd0;
        WDATA_A = 4'h0; WDATA_B = 4'h0;
        #2 RESET = 1'b0;

        // Reset state
        @(negedge CLK);
        chk("rst count", {5'd0, COUNT}, 8'h00);
        chk("rst gnt/done/err", {2'd0, GNT_A, GNT_B, DONE_A, DONE_B, ERR_A, ERR_B}, 8'h00);
        chk("rst rdata", {RDATA_A, RDATA_B}, 8'h00);
        chk("rst stk bus", {1'b0, STK_OE, STK_COMMAND, STK_DOUT}, 8'h00);
        chk("rst stk_reset", {7'd0, STK_RESET}, 8'h01);
        @(negedge CLK);
        RESET = 1'b1;
        #1 chk("stk_reset after release", {7'd0, STK_RESET}, 8'h01);
        @(negedge CLK);
        chk("stk_reset cleared", {7'd0, STK_RESET}, 8'h00);

        // Pushes by A, then B pops and reads
        do_op("A push 3", 1, 0, 0, 2'b01, 3'd0, 4'h3, 0, 4'h0, 3'd1, lat);
        do_op("A push 7", 1, 0, 0, 2'b01, 3'd0, 4'h7, 0, 4'h0, 3'd2, lat);
        do_op("B pop", 0, 1, 1, 2'b10, 3'd0, 4'h0, 0, 4'h7, 3'd1, lat);
        do_op("B get0", 0, 1, 1, 2'b11, 3'd0, 4'h0, 0, 4'h3, 3'd1, lat);

        // Simultaneous requests alternate A, B, A
        do_op("tie1", 1, 1, 0, 2'b00, 3'd0, 4'h0, 0, 4'h0, 3'd1, lat);
        do_op("tie2", 1, 1, 1, 2'b00, 3'd0, 4'h0, 0, 4'h0, 3'd1, lat);
        do_op("tie3", 1, 1, 0, 2'b00, 3'd0, 4'h0, 0, 4'h0, 3'd1, lat);

        // Empty boundary
        do_op("A pop last", 1, 0, 0, 2'b10, 3'd0, 4'h0, 0, 4'h3, 3'd0, lat);
        do_op("B pop empty", 0, 1, 1, 2'b10, 3'd0, 4'h0, 1, 4'h0, 3'd0, lat);

        // Full boundary
        for (int i = 1; i <= 5; i++)
            do_op("A fill", 1, 0, 0, 2'b01, 3'd0, 4'(i), 0, 4'h0, 3'(i), lat);
        do_op("B push full", 0, 1, 1, 2'b01, 3'd0, 4'h9, 1, 4'h0, 3'd5, lat);
        do_op("A pop5", 1, 0, 0, 2'b10, 3'd0, 4'h0, 0, 4'h5, 3'd4, lat);
        do_op("A pop4", 1, 0, 0, 2'b10, 3'd0, 4'h0, 0, 4'h4, 3'd3, lat);
        do_op("A pop3", 1, 0, 0, 2'b10, 3'd0, 4'h0, 0, 4'h3, 3'd2, lat);

        // GET index boundary at COUNT=2
        do_op("B get1", 0, 1, 1, 2'b11, 3'd1, 4'h0, 0, 4'h1, 3'd2, lat);
        do_op("B get2 bad", 0, 1, 1, 2'b11, 3'd2, 4'h0, 1, 4'h0, 3'd2, lat);
        do_op("A push 6", 1, 0, 0, 2'b01, 3'd0, 4'h6, 0, 4'h0, 3'd3, lat);

        // Reset during WAIT of a POP by A (A served last, so B would win a tie without reset)
        REQ_A = 1'b1; CMD_A = 2'b10;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!GNT_A && lat < 10);
        chk("abort gnt", {6'd0, GNT_A, GNT_B}, 8'h02);
        REQ_A = 1'b0; CMD_A = 2'b00;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("abort count", {5'd0, COUNT}, 8'h00);
        chk("abort stk_reset", {7'd0, STK_RESET}, 8'h01);
        chk("abort rdata", {RDATA_A, RDATA_B}, 8'h00);
        chk("abort outputs", {2'd0, GNT_A, GNT_B, DONE_A, DONE_B, ERR_A, ERR_B}, 8'h00);
        rd_a_exp = 4'h0;
        rd_b_exp = 4'h0;
        @(negedge CLK);
        chk("abort no done 1", {6'd0, DONE_A, DONE_B}, 8'h00);
        @(negedge CLK);
        chk("abort no done 2", {6'd0, DONE_A, DONE_B}, 8'h00);
        RESET = 1'b1;
        REQ_A = 1'b1; CMD_A = 2'b10;
        REQ_B = 1'b1; CMD_B = 2'b10;
        #1 chk("post-abort stk_reset", {7'd0, STK_RESET}, 8'h01);
        @(negedge CLK);
        chk("post-abort stk_reset low", {7'd0, STK_RESET}, 8'h00);
        chk("post-abort no early gnt", {6'd0, GNT_A, GNT_B}, 8'h00);
        do_op("re-req tie", 1, 1, 0, 2'b10, 3'd0, 4'h0, 1, 4'h0, 3'd0, lat);
        chk("re-req latency", 8'(lat), 8'd1);
        do_op("B pop after", 0, 1, 1, 2'b10, 3'd0, 4'h0, 1, 4'h0, 3'd0, lat);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 5, stack entries (count range 0..DEPTH).
REQ-002 SHALL have parameter WIDTH, default 4, data word width.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports REQ_A, REQ_B  input  1 each  client request, held high until GNT.
REQ-006 SHALL have ports CMD_A, CMD_B  input  2 each  00 NOP, 01 PUSH, 10 POP, 11 GET.
REQ-007 SHALL have ports IDX_A, IDX_B  input  3 each  GET depth below top (0 = top).
REQ-008 SHALL have ports WDATA_A, WDATA_B  input  WIDTH each  PUSH data.
REQ-009 SHALL have ports GNT_A, GNT_B  output  1 each  one-cycle grant pulse.
REQ-010 SHALL have ports DONE_A, DONE_B  output  1 each  one-cycle completion pulse.
REQ-011 SHALL have ports ERR_A, ERR_B  output  1 each  valid with DONE; request rejected.
REQ-012 SHALL have ports RDATA_A, RDATA_B  output  WIDTH each  POP/GET result, registered.
REQ-013 SHALL have ports STK_COMMAND  output  2, STK_INDEX  output  3  drive the stack command bus.
REQ-014 SHALL have ports STK_DOUT  output  WIDTH, STK_OE  output  1  push data and its tristate enable.
REQ-015 SHALL have port STK_DIN  input  WIDTH  stack data bus read-back.
REQ-016 SHALL have port STK_RESET  output  1  active-high clear to the stack.
REQ-017 SHALL have port COUNT  output  3  current occupancy 0..DEPTH.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE, one op per 4 cycles.
REQ-019 IDLE: at posedge with REQ_A or REQ_B high, SHALL latch the winner's CMD/IDX/WDATA, go to ISSUE.
REQ-020 Arbitration SHALL be round-robin: a single requester wins; on tie, the client not served last wins; after reset A has priority.
REQ-021 ISSUE: SHALL pulse GNT of the winner; SHALL drive STK_COMMAND/STK_INDEX from the latch; STK_OE=1 and STK_DOUT=data only for a legal PUSH.
REQ-022 All states other than ISSUE SHALL drive STK_COMMAND=00, STK_OE=0, STK_DOUT=0.
REQ-023 Legality: PUSH illegal when COUNT==DEPTH; POP illegal when COUNT==0; GET illegal when IDX>=COUNT; NOP always legal.
REQ-024 An illegal or NOP request SHALL drive STK_COMMAND=00 in ISSUE and SHALL NOT change COUNT.
REQ-025 Leaving ISSUE, COUNT SHALL increment on legal PUSH and decrement on legal POP, else hold.
REQ-026 WAIT: at the closing posedge, SHALL register STK_DIN into the winner's RDATA for legal POP/GET; RDATA SHALL load 0 for PUSH, NOP and illegal ops.
REQ-027 DONE: SHALL pulse the winner's DONE; ERR=1 exactly for illegal requests; the loser's outputs SHALL stay 0/unchanged.
REQ-028 RDATA of each client SHALL hold its value until that client's next DONE.
REQ-029 Requests arriving outside IDLE SHALL be ignored until the next IDLE; a REQ still high in IDLE after DONE SHALL be treated as a new request.
REQ-030 GNT, DONE, ERR SHALL never be high for both clients in the same cycle.
REQ-031 Latency: request sampled at posedge k -> GNT in cycle k+1 -> DONE/RDATA valid in cycle k+3.

Reset
REQ-032 RESET low SHALL immediately force FSM=IDLE, COUNT=0, all GNT/DONE/ERR=0, RDATA=0, STK_COMMAND=00, STK_OE=0, STK_DOUT=0, priority=A.
REQ-033 STK_RESET SHALL be 1 while RESET is low and for the first cycle after release; no request is accepted in that cycle.
REQ-034 Reset mid-operation SHALL abort the op with no DONE issued; the client re-requests.

Verification
REQ-035 Reset, then A PUSH 4'h3, 4'h7 -> two GNT_A/DONE_A, ERR_A=0, COUNT=2, STK_COMMAND=01 only in ISSUE cycles.
REQ-036 Then B POP -> DONE_B with RDATA_B=4'h7, COUNT=1; B GET IDX=0 -> RDATA_B=4'h3, COUNT=1.
REQ-037 A and B request in the same cycle three times -> grants A, B, A; no dual grant.
REQ-038 POP at COUNT=0, PUSH at COUNT=5, GET IDX=2 at COUNT=2 -> DONE with ERR=1, STK_COMMAND stays 00, COUNT unchanged.
REQ-039 RESET low during WAIT of a POP -> no DONE, COUNT=0, STK_RESET high through the first post-release cycle.
